// File: rtl/y86_instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// y86_instr_encoder_pkg
//   Shared Y86-64 instruction-set definitions for the instruction encoder and
//   the fetch stage.
//   Contents:
//     ICODE_*        instruction codes 0x0..0xB
//     REG_NONE       register specifier meaning "no register"
//     enc_state_e    encoder FSM states (also exported on the debug port)
//     instr_info_t   per-icode encoding facts produced by y86_instr_encoder_len
//     instr_len()    instruction length in bytes, 0 for an illegal icode
// ---------------------------------------------------------------------------
package y86_instr_encoder_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;  // also cmovxx
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE     = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } enc_state_e;

    // valc_offset: byte index of the MSB of valC (0 = no valC field)
    typedef struct packed {
        logic       valid;
        logic [3:0] len;
        logic       has_regs;
        logic [1:0] valc_offset;
    } instr_info_t;

    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_RET:                  instr_len = 4'd1;
            ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ:  instr_len = 4'd2;
            ICODE_JXX, ICODE_CALL:                             instr_len = 4'd9;
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:          instr_len = 4'd10;
            default:                                           instr_len = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/y86_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// y86_instr_encoder_if
//   Decoded-instruction handshake into the encoder.
//   Signals:
//     in_valid   producer has instruction fields on the bus
//     in_ready   encoder can take them this cycle
//     in_icode / in_ifun / in_rA / in_rB / in_valC   instruction fields
//   Handshake: a transfer happens on a rising clk edge where in_valid and
//   in_ready are both high. The producer holds the fields stable while
//   in_valid is high and may not drop in_valid before the transfer; in_ready
//   may change freely and does not depend on in_valid.
//   Modports: master = producer, slave = encoder.
// ---------------------------------------------------------------------------
interface y86_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic [3:0]  in_ifun;
    logic [3:0]  in_rA;
    logic [3:0]  in_rB;
    logic [63:0] in_valC;

    modport master (
        output in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC,
        output in_ready
    );
endinterface

// File: rtl/y86_instr_encoder_len.sv
// ---------------------------------------------------------------------------
// y86_instr_encoder_len
//   Combinational icode decoder giving the byte layout of an instruction.
//   Shared with fetch, which uses len to compute valP.
//   Ports:
//     icode  in   4   instruction code
//     info   out  -   {valid, len, has_regs, valc_offset}
// ---------------------------------------------------------------------------
module y86_instr_encoder_len
    import y86_instr_encoder_pkg::*;
(
    input  logic [3:0]  icode,
    output instr_info_t info
);

    always_comb begin
        info             = '0;
        info.len         = instr_len(icode);
        info.valid       = (info.len != 4'd0);

        case (icode)
            ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ,
            ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: info.has_regs = 1'b1;
            default:                            info.has_regs = 1'b0;
        endcase

        case (icode)
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: info.valc_offset = 2'd2;
            ICODE_JXX, ICODE_CALL:                    info.valc_offset = 2'd1;
            default:                                  info.valc_offset = 2'd0;
        endcase
    end

endmodule

// File: rtl/y86_instr_encoder.sv
// ---------------------------------------------------------------------------
// y86_instr_encoder
//   Serialises decoded Y86-64 instructions into byte writes to the 1 KiB
//   instruction memory, one byte per cycle, in the layout fetch decodes
//   (valC stored MSB first).
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     ptr_load, ptr_value load the write pointer (honoured in IDLE only)
//     in_if               instruction handshake (slave side)
//     mem_we/addr/wdata   byte write port to instruction memory
//     next_pc             address the next instruction will be written to
//     instr_count         instructions completely written since reset
//     err_invalid         sticky: icode > 0xB was offered
//     err_overflow        sticky: an instruction would cross IMEM_DEPTH
//     dbg_state           current FSM state
// ---------------------------------------------------------------------------
module y86_instr_encoder
    import y86_instr_encoder_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [63:0] RESET_ADDR = 64'd0
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ptr_load,
    input  logic [63:0]          ptr_value,
    y86_instr_encoder_if.slave   in_if,
    output logic                 mem_we,
    output logic [63:0]          mem_addr,
    output logic [7:0]           mem_wdata,
    output logic [63:0]          next_pc,
    output logic [31:0]          instr_count,
    output logic                 err_invalid,
    output logic                 err_overflow,
    output enc_state_e           dbg_state
);

    instr_info_t info;

    enc_state_e  state_q, state_d;
    logic        ready_q, ready_d;
    logic        mem_we_d;
    logic [63:0] mem_addr_d;
    logic [7:0]  mem_wdata_d;
    logic [63:0] pc_d;
    logic [31:0] count_d;
    logic        err_inv_d, err_ovf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  len_q, len_d;
    logic [79:0] shreg_q, shreg_d;

    logic [79:0] word;
    logic [7:0]  byte0, byte1;
    logic        accept;
    logic        overflow;

    y86_instr_encoder_len u_len (
        .icode (in_if.in_icode),
        .info  (info)
    );

    // A pointer load wins over an offered instruction in the same cycle.
    assign in_if.in_ready = ready_q & ~ptr_load;
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign dbg_state      = state_q;

    // 65-bit sum so a huge loaded pointer cannot wrap past the check.
    assign overflow = ({1'b0, next_pc} + 65'(info.len)) > 65'(IMEM_DEPTH);

    // Left-aligned instruction image: byte 0 sits in word[79:72].
    assign byte0 = {in_if.in_icode, in_if.in_ifun};
    assign byte1 = {in_if.in_rA, in_if.in_rB};

    always_comb begin
        word = {byte0, 72'h0};
        case (info.valc_offset)
            2'd2:    word = {byte0, byte1, in_if.in_valC};
            2'd1:    word = {byte0, in_if.in_valC, 8'h0};
            default: word = info.has_regs ? {byte0, byte1, 64'h0} : {byte0, 72'h0};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        pc_d        = next_pc;
        count_d     = instr_count;
        err_inv_d   = err_invalid;
        err_ovf_d   = err_overflow;
        cnt_d       = cnt_q;
        len_d       = len_q;
        shreg_d     = shreg_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (ptr_load) begin
                    pc_d = ptr_value;
                end else if (accept) begin
                    if (!info.valid) begin
                        err_inv_d = 1'b1;
                    end else if (overflow) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        // Byte 0 goes out on the cycle right after the handshake.
                        state_d     = ST_EMIT;
                        ready_d     = 1'b0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = next_pc;
                        mem_wdata_d = word[79:72];
                        shreg_d     = {word[71:0], 8'h0};
                        pc_d        = next_pc + 64'd1;
                        cnt_d       = 4'd1;
                        len_d       = info.len;
                    end
                end
            end
            ST_EMIT: begin
                if (cnt_q == len_q) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    count_d = instr_count + 32'd1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = next_pc;
                    mem_wdata_d = shreg_q[79:72];
                    shreg_d     = {shreg_q[71:0], 8'h0};
                    pc_d        = next_pc + 64'd1;
                    cnt_d       = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 64'd0;
            mem_wdata    <= 8'd0;
            next_pc      <= RESET_ADDR;
            instr_count  <= 32'd0;
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
            cnt_q        <= 4'd0;
            len_q        <= 4'd0;
            shreg_q      <= 80'd0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            next_pc      <= pc_d;
            instr_count  <= count_d;
            err_invalid  <= err_inv_d;
            err_overflow <= err_ovf_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            shreg_q      <= shreg_d;
        end
    end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_y86_instr_encoder
//   Self-checking bench for y86_instr_encoder: directed scenarios followed by
//   randomized instructions, with a byte-write scoreboard fed by a reference
//   model and a monitor that checks every memory write.
// ---------------------------------------------------------------------------
module tb_y86_instr_encoder;
    import y86_instr_encoder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ptr_load;
    logic [63:0] ptr_value;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [63:0] next_pc;
    logic [31:0] instr_count;
    logic        err_invalid;
    logic        err_overflow;
    enc_state_e  dbg_state;

    y86_instr_encoder_if enc_if ();

    y86_instr_encoder #(
        .IMEM_DEPTH (1024),
        .RESET_ADDR (64'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ptr_load     (ptr_load),
        .ptr_value    (ptr_value),
        .in_if        (enc_if.slave),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .next_pc      (next_pc),
        .instr_count  (instr_count),
        .err_invalid  (err_invalid),
        .err_overflow (err_overflow),
        .dbg_state    (dbg_state)
    );

    // ---------------- reference model state ----------------
    int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};
    logic [63:0] m_pc;
    logic [31:0] m_count;
    logic        m_err_inv;
    logic        m_err_ovf;
    logic [7:0]  mem [1024];

    // scoreboard: {addr, data} per expected byte write
    logic [71:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pc      = 64'd0;
        m_count   = 32'd0;
        m_err_inv = 1'b0;
        m_err_ovf = 1'b0;
        exp_q.delete();
    endtask

    // Encode one instruction from the ISA rules and predict its byte writes.
    task automatic model_accept(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc);
        logic [7:0] bytes [$];
        int len;
        len = len_tab[ic];
        if (len == 0) begin
            m_err_inv = 1'b1;
        end else if (m_pc + 64'(len) > 64'd1024) begin
            m_err_ovf = 1'b1;
        end else begin
            bytes.push_back({ic, fn});
            if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB})
                bytes.push_back({ra, rb});
            if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
                for (int k = 7; k >= 0; k--) bytes.push_back(vc[k*8 +: 8]);
            for (int i = 0; i < bytes.size(); i++)
                exp_q.push_back({m_pc + 64'(i), bytes[i]});
            m_pc    = m_pc + 64'(len);
            m_count = m_count + 32'd1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [71:0] item;
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected",
                         mem_addr, mem_wdata);
            end else begin
                item = exp_q.pop_front();
                check("wr_addr", mem_addr, 64'(item[71:8]));
                check("wr_data", 64'(mem_wdata), 64'(item[7:0]));
            end
            if (mem_addr < 64'd1024) mem[mem_addr[9:0]] = mem_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (enc_if.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            $display("FAIL idle_timeout: in_ready stayed %b", enc_if.in_ready);
        end
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc);
        wait_idle();
        enc_if.in_icode = ic;
        enc_if.in_ifun  = fn;
        enc_if.in_rA    = ra;
        enc_if.in_rB    = rb;
        enc_if.in_valC  = vc;
        enc_if.in_valid = 1'b1;
        @(posedge clk);
        model_accept(ic, fn, ra, rb, vc);
        #1 enc_if.in_valid = 1'b0;
    endtask

    task automatic load_ptr(input logic [63:0] v);
        wait_idle();
        ptr_load  = 1'b1;
        ptr_value = v;
        #1 check("ready_low_on_load", 64'(enc_if.in_ready), 64'd0);
        @(posedge clk);
        m_pc = v;
        #1 ptr_load = 1'b0;
    endtask

    task automatic status(input string tag);
        wait_idle();
        check({tag, "_next_pc"}, next_pc, m_pc);
        check({tag, "_instr_count"}, 64'(instr_count), 64'(m_count));
        check({tag, "_err_invalid"}, 64'(err_invalid), 64'(m_err_inv));
        check({tag, "_err_overflow"}, 64'(err_overflow), 64'(m_err_ovf));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [63:0] valc_rt;
        logic [3:0]  ic;

        rst_n           = 1'b0;
        ptr_load        = 1'b0;
        ptr_value       = 64'd0;
        enc_if.in_valid = 1'b0;
        enc_if.in_icode = 4'h0;
        enc_if.in_ifun  = 4'h0;
        enc_if.in_rA    = 4'hF;
        enc_if.in_rB    = 4'hF;
        enc_if.in_valC  = 64'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        model_reset();

        // reset values
        repeat (2) @(negedge clk);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_next_pc", next_pc, 64'd0);
        check("rst_instr_count", 64'(instr_count), 64'd0);
        check("rst_errors", 64'({err_invalid, err_overflow}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_release", 64'(enc_if.in_ready), 64'd1);

        // OPq rA=2 rB=3 at 0
        send(ICODE_OPQ, 4'h0, 4'h2, 4'h3, 64'd0);
        status("opq");
        check("opq_mem0", 64'(mem[0]), 64'h60);
        check("opq_mem1", 64'(mem[1]), 64'h23);

        // irmovq rB=2 valC=0x11 at 2, then decode it back as fetch would
        send(ICODE_IRMOVQ, 4'h0, REG_NONE, 4'h2, 64'h11);
        status("irmovq");
        check("irmovq_mem2", 64'(mem[2]), 64'h30);
        check("irmovq_mem3", 64'(mem[3]), 64'hF2);
        valc_rt = 64'd0;
        for (int i = 4; i < 12; i++) valc_rt = {valc_rt[55:0], mem[i]};
        check("fetch_valC", valc_rt, 64'h11);
        check("fetch_valP", 64'd2 + 64'(len_tab[mem[2][7:4]]), 64'd12);

        // call at 1014 fills to 1022, nop exactly fits at 1023, next nop overflows
        load_ptr(64'd1014);
        send(ICODE_CALL, 4'h0, REG_NONE, REG_NONE, 64'h20);
        send(ICODE_NOP, 4'h0, REG_NONE, REG_NONE, 64'd0);
        status("exact_fit");
        check("call_mem1014", 64'(mem[1014]), 64'h80);
        check("call_mem1022", 64'(mem[1022]), 64'h20);
        check("nop_mem1023", 64'(mem[1023]), 64'h10);
        send(ICODE_NOP, 4'h0, REG_NONE, REG_NONE, 64'd0);
        status("overflow");

        // illegal icode
        send(4'hC, 4'h0, REG_NONE, REG_NONE, 64'd0);
        status("invalid");
        check("invalid_ready", 64'(enc_if.in_ready), 64'd1);

        // ptr_load and in_valid together: load wins, instruction taken next cycle
        wait_idle();
        ptr_load        = 1'b1;
        ptr_value       = 64'd100;
        enc_if.in_icode = ICODE_OPQ;
        enc_if.in_ifun  = 4'h1;
        enc_if.in_rA    = 4'h4;
        enc_if.in_rB    = 4'h5;
        enc_if.in_valC  = 64'd0;
        enc_if.in_valid = 1'b1;
        #1 check("load_beats_valid_ready", 64'(enc_if.in_ready), 64'd0);
        @(posedge clk);
        m_pc = 64'd100;
        #1 ptr_load = 1'b0;
        @(negedge clk);
        check("ready_after_load", 64'(enc_if.in_ready), 64'd1);
        @(posedge clk);
        model_accept(ICODE_OPQ, 4'h1, 4'h4, 4'h5, 64'd0);
        #1 enc_if.in_valid = 1'b0;
        status("load_then_accept");
        check("load_accept_mem100", 64'(mem[100]), 64'h61);

        // reset during the 4th byte of an irmovq
        send(ICODE_IRMOVQ, 4'h0, REG_NONE, 4'h3, 64'h0123_4567_89AB_CDEF);
        repeat (3) @(posedge clk);
        #1 check("mid_emit_we", 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", 64'(mem_we), 64'd0);
        check("async_rst_next_pc", next_pc, 64'd0);
        check("async_rst_count", 64'(instr_count), 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_mid_reset", 64'(enc_if.in_ready), 64'd1);

        // randomized instructions
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) load_ptr(64'($urandom_range(0, 1023)));
            if ($urandom_range(0, 9) == 0) ic = 4'($urandom_range(12, 15));
            else                           ic = 4'($urandom_range(0, 11));
            send(ic, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), {$urandom, $urandom});
            if (n % 10 == 9) status("rand");
        end
        status("final");

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d expected writes never seen (wanted 0)", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
